mem_stage: RTL and testbench

Pipeline MEM stage of the RV64 core: consumes the instruction leaving execute and produces the record entering writeback.
- Loads and stores issue one data-bus transaction each; the stage holds the pipeline until the bus acknowledges.
- Load data is aligned and sign/zero-extended; store data and byte strobes are lane-placed.
- Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV64 pipeline MEM stage. Issues one data-bus transaction per
// load/store, holds the pipeline until the bus acknowledges, aligns and
// extends load data, lane-places store data and byte strobes, and passes
// non-memory records through with one cycle of latency.
//
// Handshakes: a record moves across a valid/ready pair on a clock edge where
// both are high; valid must not depend on ready. The data-bus request has no
// ready: dreq_* stay stable from issue until the edge where dresp_data_ok is
// sampled high.
module mem_stage #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [1:0]      in_mem_op,
  input  logic [1:0]      in_mem_size,
  input  logic            in_unsigned,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [RW-1:0]   out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_data,
  output logic            out_misaligned,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [1:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  state_t state, state_next;

  logic            accept;
  logic            is_mem;
  logic            misaligned;
  logic            issue;
  logic            done;
  logic [2:0]      off;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] load_shift;
  logic [XLEN-1:0] load_val;

  // Record fields kept while the bus transaction is outstanding.
  logic [XLEN-1:0] pend_pc;
  logic [RW-1:0]   pend_rd;
  logic            pend_wen;
  logic            pend_store;
  logic            pend_unsigned;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = (in_mem_op == 2'd1) || (in_mem_op == 2'd2);
  assign off      = in_result[2:0];
  assign issue    = accept && is_mem && !misaligned;
  assign done     = (state == WAIT) && dresp_data_ok;

  // Alignment check and byte-mask width for the incoming access size.
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (in_mem_size)
      2'd0: begin misaligned = 1'b0;             size_mask = 8'h01; end
      2'd1: begin misaligned = in_result[0];     size_mask = 8'h03; end
      2'd2: begin misaligned = |in_result[1:0];  size_mask = 8'h0f; end
      default: begin misaligned = |in_result[2:0]; size_mask = 8'hff; end
    endcase
  end

  // Load data: shift the addressed lane down, then extend per size/signedness.
  // The outstanding request's address and size are the authoritative copy.
  always_comb begin
    load_shift = dresp_data >> {dreq_addr[2:0], 3'b000};
    load_val   = load_shift;
    case (dreq_size)
      2'd0: load_val = pend_unsigned ? {{(XLEN-8){1'b0}}, load_shift[7:0]}
                                     : {{(XLEN-8){load_shift[7]}}, load_shift[7:0]};
      2'd1: load_val = pend_unsigned ? {{(XLEN-16){1'b0}}, load_shift[15:0]}
                                     : {{(XLEN-16){load_shift[15]}}, load_shift[15:0]};
      2'd2: load_val = pend_unsigned ? {{(XLEN-32){1'b0}}, load_shift[31:0]}
                                     : {{(XLEN-32){load_shift[31]}}, load_shift[31:0]};
      default: load_val = load_shift;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: enter WAIT on an aligned memory op, leave on bus completion.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue)         state_next = WAIT;
      WAIT: if (dresp_data_ok) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Request registers, pending record and writeback output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dreq_valid     <= 1'b0;
      dreq_addr      <= '0;
      dreq_size      <= '0;
      dreq_strobe    <= '0;
      dreq_data      <= '0;
      pend_pc        <= '0;
      pend_rd        <= '0;
      pend_wen       <= 1'b0;
      pend_store     <= 1'b0;
      pend_unsigned  <= 1'b0;
      out_valid      <= 1'b0;
      out_pc         <= '0;
      out_rd         <= '0;
      out_wen        <= 1'b0;
      out_data       <= '0;
      out_misaligned <= 1'b0;
    end else begin
      if (issue) begin
        dreq_valid    <= 1'b1;
        dreq_addr     <= in_result;
        dreq_size     <= in_mem_size;
        dreq_strobe   <= (in_mem_op == 2'd2) ? (size_mask << off) : 8'h00;
        dreq_data     <= (in_mem_op == 2'd2) ? (in_store_data << {off, 3'b000}) : '0;
        pend_pc       <= in_pc;
        pend_rd       <= in_rd;
        pend_wen      <= in_wen;
        pend_store    <= (in_mem_op == 2'd2);
        pend_unsigned <= in_unsigned;
      end else if (done) begin
        dreq_valid <= 1'b0;
      end

      if (accept && !issue) begin
        // Non-memory record, or memory op rejected for misalignment.
        out_valid      <= 1'b1;
        out_pc         <= in_pc;
        out_rd         <= in_rd;
        out_wen        <= is_mem ? 1'b0 : in_wen;
        out_data       <= in_result;
        out_misaligned <= is_mem;
      end else if (done) begin
        out_valid      <= 1'b1;
        out_pc         <= pend_pc;
        out_rd         <= pend_rd;
        out_wen        <= pend_store ? 1'b0 : pend_wen;
        out_data       <= pend_store ? dreq_addr : load_val;
        out_misaligned <= 1'b0;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, hand-written corner sequences and random
// operations compared against a byte-level behavioural model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_result;
  logic [63:0] in_store_data;
  logic [1:0]  in_mem_op;
  logic [1:0]  in_mem_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [63:0] out_data;
  logic        out_misaligned;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  mem_stage #(.XLEN(64), .RW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_result(in_result), .in_store_data(in_store_data),
    .in_mem_op(in_mem_op), .in_mem_size(in_mem_size),
    .in_unsigned(in_unsigned), .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_wen(out_wen), .out_data(out_data),
    .out_misaligned(out_misaligned),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  // Clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] sdata;
    logic [63:0] bus;
    int          lat;
    logic [63:0] e_data;
    logic        e_wen;
    logic        e_mis;
    logic [7:0]  e_strobe;
    logic [63:0] e_sdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: byte-level view of the access.
  function automatic logic model_mis(input logic [1:0] op, input logic [1:0] size, input logic [63:0] addr);
    int n;
    n = 1 << size;
    return (op == 2'd1 || op == 2'd2) && ((addr % 64'(n)) != 0);
  endfunction

  function automatic logic [63:0] model_data(input logic [1:0] op, input logic [1:0] size,
                                             input logic uns, input logic [63:0] addr,
                                             input logic [63:0] bus);
    int n;
    logic [63:0] v;
    logic [63:0] m;
    n = 1 << size;
    if (op != 2'd1 || model_mis(op, size, addr)) return addr;
    v = bus >> (8 * int'(addr[2:0]));
    if (n == 8) return v;
    m = (64'd1 << (8 * n)) - 64'd1;
    v = v & m;
    if (!uns && v[8 * n - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(input logic [1:0] op, input logic [1:0] size, input logic [63:0] addr);
    logic [7:0] s;
    int o;
    s = 8'h00;
    o = int'(addr[2:0]);
    if (op == 2'd2)
      for (int i = 0; i < 8; i++)
        if (i >= o && i < o + (1 << size)) s[i] = 1'b1;
    return s;
  endfunction

  // Driver: present one record, act as the bus, then score the output.
  task automatic run_op(input logic [1:0] op, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] sdata,
                        input logic [63:0] bus, input int lat, input logic wen,
                        input logic [63:0] e_data, input logic e_wen, input logic e_mis,
                        input logic [7:0] e_strobe, input logic [63:0] e_sdata);
    logic [63:0] pc;
    logic [4:0]  rd;
    logic        go_bus;
    pc = {$urandom, $urandom};
    rd = 5'($urandom_range(0, 31));
    go_bus = (op == 2'd1 || op == 2'd2) && !e_mis;
    exp_q.push_back(e_data);
    in_valid = 1'b1; in_pc = pc; in_result = addr; in_store_data = sdata;
    in_mem_op = op; in_mem_size = size; in_unsigned = uns; in_rd = rd; in_wen = wen;
    chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (go_bus) begin
      chk("dreq_valid", {63'd0, dreq_valid}, 64'd1);
      chk("dreq_addr", dreq_addr, addr);
      chk("dreq_size", {62'd0, dreq_size}, {62'd0, size});
      chk("dreq_strobe", {56'd0, dreq_strobe}, {56'd0, e_strobe});
      if (op == 2'd2) chk("dreq_data", dreq_data, e_sdata);
      chk("in_ready_wait", {63'd0, in_ready}, 64'd0);
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); #1;
        chk("dreq_hold", {63'd0, dreq_valid}, 64'd1);
        chk("addr_hold", dreq_addr, addr);
        chk("strobe_hold", {56'd0, dreq_strobe}, {56'd0, e_strobe});
        chk("in_ready_wait", {63'd0, in_ready}, 64'd0);
        chk("out_valid_wait", {63'd0, out_valid}, 64'd0);
      end
      dresp_data_ok = 1'b1; dresp_data = bus;
      @(posedge clk); #1;
      dresp_data_ok = 1'b0; dresp_data = {$urandom, $urandom};
      chk("dreq_drop", {63'd0, dreq_valid}, 64'd0);
    end else begin
      chk("no_dreq", {63'd0, dreq_valid}, 64'd0);
    end
    chk("out_valid", {63'd0, out_valid}, 64'd1);
    chk("out_pc", out_pc, pc);
    chk("out_rd", {59'd0, out_rd}, {59'd0, rd});
    chk("out_wen", {63'd0, out_wen}, {63'd0, e_wen});
    chk("out_mis", {63'd0, out_misaligned}, {63'd0, e_mis});
    chk("out_data", out_data, exp_q.pop_front());
  endtask

  vec_t vecs[10];

  initial begin
    logic [63:0] pt[3];
    logic [1:0]  op, size;
    logic        uns, wen, mis;
    logic [63:0] addr, sdata, bus;

    // Reset.
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_result = '0; in_store_data = '0;
    in_mem_op = '0; in_mem_size = '0; in_unsigned = 1'b0; in_rd = '0; in_wen = 1'b0;
    out_ready = 1'b1; dresp_data_ok = 1'b0; dresp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dreq_valid", {63'd0, dreq_valid}, 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_dreq_strobe", {56'd0, dreq_strobe}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_wen", {63'd0, out_wen}, 64'd0);
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Vector table: op size uns addr sdata bus lat | data wen mis strobe sdata.
    vecs[0] = '{2'd0, 2'd0, 1'b0, 64'h11, 64'h0, 64'h0, 0, 64'h11, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[1] = '{2'd1, 2'd0, 1'b0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3,
                64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[2] = '{2'd2, 2'd1, 1'b0, 64'h2006, 64'hABCD, 64'h0, 1,
                64'h2006, 1'b0, 1'b0, 8'hC0, 64'hABCD_0000_0000_0000};
    vecs[3] = '{2'd1, 2'd2, 1'b0, 64'h1002, 64'h0, 64'h0, 0, 64'h1002, 1'b0, 1'b1, 8'h00, 64'h0};
    vecs[4] = '{2'd1, 2'd1, 1'b1, 64'h100A, 64'h0, 64'h1122_3344_5566_7788, 0,
                64'h5566, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[5] = '{2'd1, 2'd2, 1'b0, 64'h4004, 64'h0, 64'h8765_4321_0000_0000, 2,
                64'hFFFF_FFFF_8765_4321, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[6] = '{2'd1, 2'd3, 1'b1, 64'h8, 64'h0, 64'hF000_0000_0000_0001, 1,
                64'hF000_0000_0000_0001, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[7] = '{2'd3, 2'd2, 1'b0, 64'h55, 64'h0, 64'h0, 0, 64'h55, 1'b1, 1'b0, 8'h00, 64'h0};
    vecs[8] = '{2'd2, 2'd0, 1'b0, 64'h7, 64'hAB, 64'h0, 0,
                64'h7, 1'b0, 1'b0, 8'h80, 64'hAB00_0000_0000_0000};
    vecs[9] = '{2'd2, 2'd3, 1'b0, 64'h10, 64'h0123_4567_89AB_CDEF, 64'h0, 2,
                64'h10, 1'b0, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF};
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].sdata,
             vecs[i].bus, vecs[i].lat, 1'b1, vecs[i].e_data, vecs[i].e_wen,
             vecs[i].e_mis, vecs[i].e_strobe, vecs[i].e_sdata);

    // Pass-through: three back-to-back ALU ops.
    pt[0] = 64'h11; pt[1] = 64'h22; pt[2] = 64'h33;
    in_mem_op = 2'd0; in_wen = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_result = pt[i];
      #1;
      chk("pt_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      chk("pt_out_data", out_data, pt[i]);
      chk("pt_out_valid", {63'd0, out_valid}, 64'd1);
      chk("pt_no_dreq", {63'd0, dreq_valid}, 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pt_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0; in_valid = 1'b1; in_mem_op = 2'd0; in_result = 64'h99; in_pc = 64'h400;
    @(posedge clk); #1;
    chk("bp_first", out_data, 64'h99);
    in_result = 64'hAA; in_pc = 64'h404;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", out_data, 64'h99);
      chk("bp_hold_pc", out_pc, 64'h400);
      chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_resume_data", out_data, 64'hAA);
    @(posedge clk); #1;

    // Reset mid-WAIT; a late response must be ignored.
    in_valid = 1'b1; in_mem_op = 2'd1; in_mem_size = 2'd3; in_result = 64'h3000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rw_dreq", {63'd0, dreq_valid}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("rw_dreq_low", {63'd0, dreq_valid}, 64'd0);
    chk("rw_out_low", {63'd0, out_valid}, 64'd0);
    chk("rw_addr_clr", dreq_addr, 64'd0);
    dresp_data_ok = 1'b1; dresp_data = 64'hDEAD;
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    chk("rw_late_ok", {63'd0, out_valid}, 64'd0);
    chk("rw_late_dreq", {63'd0, dreq_valid}, 64'd0);
    chk("rw_in_ready", {63'd0, in_ready}, 64'd1);

    // Random operations against the model.
    for (int k = 0; k < 60; k++) begin
      op    = 2'($urandom_range(0, 3));
      size  = 2'($urandom_range(0, 3));
      uns   = 1'($urandom_range(0, 1));
      wen   = 1'($urandom_range(0, 1));
      addr  = {$urandom, $urandom};
      sdata = {$urandom, $urandom};
      bus   = {$urandom, $urandom};
      mis   = model_mis(op, size, addr);
      run_op(op, size, uns, addr, sdata, bus, $urandom_range(0, 3), wen,
             model_data(op, size, uns, addr, bus),
             (op == 2'd2 || mis) ? 1'b0 : wen, mis,
             model_strobe(op, size, addr),
             sdata << (8 * int'(addr[2:0])));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
